key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Multi-channel push-button conditioner; sits directly upstream of the event-synchronisation stage.
- Turns raw, bouncing, asynchronous board keys into clean clk_50m-domain signals:
  - a debounced level, which feeds the btn_sync_i style inputs downstream;
  - single-cycle press and release strobes.
- Each channel is an independent 2-FF synchroniser plus a stability counter plus a 4-state FSM.

Parameters:
- N_KEYS, 4: number of key channels.
- DB_CYCLES, 500000: consecutive stable clk_50m cycles required to accept a change (10 ms at 50 MHz); legal range ≥2.
- KEY_ACTIVE_LOW, 1: 1 = key_i reads 0 when pressed (board KEY buttons); 0 = active-high.
- REPEAT_DELAY, 25000000: held cycles before the first auto-repeat strobe (only used with the optional feature).
- REPEAT_PERIOD, 5000000: cycles between auto-repeat strobes (only used with the optional feature).

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- rst_i  in  1  reset, asynchronous, active-high.
- key_i  in  N_KEYS  raw asynchronous key pins.
- btn_level_o  out  N_KEYS  debounced pressed level, 1 = pressed.
- btn_press_o  out  N_KEYS  1-cycle strobe on accepted press (and on auto-repeat).
- btn_release_o  out  N_KEYS  1-cycle strobe on accepted release.
- any_press_o  out  1  OR of btn_press_o.

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_50m.
  - Every output resets to 0.
  - Synchroniser flops reset to the released value (1 if KEY_ACTIVE_LOW, else 0).
  - Counters reset to 0; FSMs reset to IDLE.
- Synchroniser: 2 flops per channel. p = polarity-corrected output of the second flop (1 = pressed).
- Counter width: $clog2(max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). Counter saturates and never wraps.
- FSM per channel:
  - IDLE (level 0): p=1 → PRESS_WAIT, cnt=1.
  - PRESS_WAIT: p=0 → IDLE, cnt=0 (bounce rejected, no strobe). p=1 and cnt==DB_CYCLES-1 → HELD, level_o=1, press_o pulses next cycle. Otherwise cnt++.
  - HELD (level 1): p=0 → RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: p=1 → HELD, cnt=0 (no strobe). p=0 and cnt==DB_CYCLES-1 → IDLE, level_o=0, release_o pulses. Otherwise cnt++.
- Latency: a clean pin edge → btn_level_o changes exactly DB_CYCLES+2 cycles later. Strobe asserts in the same cycle as the level change, lasts exactly 1 cycle, and is registered.
- Strobe limits:
  - Never more than one press strobe per accepted press when the feature is disabled.
  - Press and release strobes never coincide on one channel.
  - Channels are fully independent; simultaneous events on several channels produce simultaneous strobes.
- Reset mid-operation (any state, including during a strobe): outputs drop to 0 immediately. No release strobe is generated. A key still held after reset deasserts is re-accepted as a new press after DB_CYCLES+2 cycles.
- Bounce shorter than DB_CYCLES never changes level_o.

Optional Feature:
- Macro: KEY_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - In HELD, a separate hold counter runs.
  - First extra press strobe fires REPEAT_DELAY cycles after the level rise; then one every REPEAT_PERIOD cycles while HELD.
  - Hold counter clears on leaving HELD.
  - RELEASE_WAIT pauses repeats; returning to HELD resumes the count without clearing it.
- Undefined: no hold counter is synthesised; exactly one press strobe per press.

Decomposition:
- Package key_debounce_pkg holds:
  - state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), 2-bit encoding;
  - counter-width function;
  - default timing constants (DB_10MS_50M, REPEAT_0S5_50M, REPEAT_0S1_50M).
- One sub-module, key_debounce_ch: a single channel (synchroniser, counter, FSM, strobes). The top is a generate loop over N_KEYS plus the any_press_o OR.

Test Plan:
- Use DB_CYCLES=8, N_KEYS=4, KEY_ACTIVE_LOW=1 throughout.
- Clean press: key_i[0] 1→0 at cycle 0, held → btn_level_o[0]=1 and btn_press_o[0] high only at cycle 10; any_press_o matches; other channels stay 0.
- Bounce rejection: key_i[1] toggles low 5 cycles / high 3 cycles, repeated 4 times, then stays high → btn_level_o[1] stays 0, zero strobes.
- Release: after the clean press, key_i[0] 0→1 at cycle 50 with a 3-cycle glitch back low at cycle 52 → glitch restarts the count; release strobe at cycle 52+3+10=65 (glitch ends at cycle 55, then DB_CYCLES+2), level 0 from then on.
- Simultaneous: key_i[3:0]=4'b0000 at one edge → btn_press_o=4'b1111 in a single cycle; later all release → btn_release_o=4'b1111 in a single cycle.
- Async reset: assert rst_i while in HELD (between clock edges) → all outputs 0 immediately, no release strobe; key still held after deassert → new press strobe 10 cycles later.
- Auto-repeat (macro defined, REPEAT_DELAY=20, REPEAT_PERIOD=6): hold 50 cycles → strobes at +0, +20, +26, +32, +38, +44 relative to the level rise; no strobes after release.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared types and constants for the key conditioner.
// Holds the per-channel state encoding, the counter-width helper and
// default 50 MHz timing constants.
package key_debounce_pkg;

   // HELD and RELEASE_WAIT share bit 1, so bit 1 is the debounced level.
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

   localparam int DB_10MS_50M    = 500000;    // 10 ms at 50 MHz
   localparam int REPEAT_0S5_50M = 25000000;  // 0.5 s at 50 MHz
   localparam int REPEAT_0S1_50M = 5000000;   // 0.1 s at 50 MHz

   // Width that holds the largest of the three timing values.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - 2-FF synchroniser, stability counter,
// 4-state debounce FSM and registered press/release strobes.
// Ports: clk_50m, rst_i (async, active-high), key_i (raw pin),
//        level_o (1 = pressed), press_o / release_o (1-cycle strobes).
// Optional auto-repeat on press_o: define KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int DB_CYCLES      = DB_10MS_50M,
   parameter bit KEY_ACTIVE_LOW = 1'b1,
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
   parameter int REPEAT_DELAY   = REPEAT_0S5_50M,
   parameter int REPEAT_PERIOD  = REPEAT_0S1_50M,
`endif
   parameter int CNT_W          = 25
) (
   input  logic clk_50m,
   input  logic rst_i,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       sync_q;
   logic             pressed;
   key_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             rpt_fire;

   // Synchroniser idles at the released pin value so reset never looks like a press.
   always_ff @(posedge clk_50m or posedge rst_i) begin
      if (rst_i) sync_q <= {2{KEY_ACTIVE_LOW}};
      else       sync_q <= {sync_q[0], key_i};
   end

   assign pressed = sync_q[1] ^ KEY_ACTIVE_LOW;
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // State register, counter and registered outputs.
   always_ff @(posedge clk_50m or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Next state: any disagreeing sample restarts the stability count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pressed) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!pressed) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (pressed) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are computed from the transition and registered, so the strobe
   // lands in the same cycle as the level change.
   always_comb begin
      level_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
      press_d   = ((state_q == PRESS_WAIT) && (state_d == HELD)) || rpt_fire;
      release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
   end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD);

   logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
   logic             rpt_q, rpt_d;

   assign hold_inc = hold_q + CNT_ONE;

   // Hold counter only advances on cycles that stay in HELD; release-wait
   // freezes it and a full release clears it.
   always_comb begin
      hold_d   = hold_q;
      rpt_d    = rpt_q;
      rpt_fire = 1'b0;
      if (state_d == IDLE) begin
         hold_d = '0;
         rpt_d  = 1'b0;
      end else if ((state_q == HELD) && (state_d == HELD)) begin
         if (hold_inc == (rpt_q ? RPT_NEXT : RPT_FIRST)) begin
            rpt_fire = 1'b1;
            hold_d   = '0;
            rpt_d    = 1'b1;
         end else begin
            hold_d   = hold_inc;
         end
      end
   end

   always_ff @(posedge clk_50m or posedge rst_i) begin
      if (rst_i) begin
         hold_q <= '0;
         rpt_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         rpt_q  <= rpt_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: N_KEYS independent push-button conditioners.
// Ports: clk_50m, rst_i (async, active-high), key_i[N_KEYS] raw pins,
//        btn_level_o / btn_press_o / btn_release_o per key, any_press_o.
// Optional auto-repeat press strobes: define KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int N_KEYS         = 4,
   parameter int DB_CYCLES      = DB_10MS_50M,
   parameter bit KEY_ACTIVE_LOW = 1'b1,
   parameter int REPEAT_DELAY   = REPEAT_0S5_50M,
   parameter int REPEAT_PERIOD  = REPEAT_0S1_50M
) (
   input  logic              clk_50m,
   input  logic              rst_i,
   input  logic [N_KEYS-1:0] key_i,
   output logic [N_KEYS-1:0] btn_level_o,
   output logic [N_KEYS-1:0] btn_press_o,
   output logic [N_KEYS-1:0] btn_release_o,
   output logic              any_press_o
);

   localparam int CNT_W = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DB_CYCLES      (DB_CYCLES),
         .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
         .CNT_W          (CNT_W)
      ) u_ch (
         .clk_50m   (clk_50m),
         .rst_i     (rst_i),
         .key_i     (key_i[g]),
         .level_o   (btn_level_o[g]),
         .press_o   (btn_press_o[g]),
         .release_o (btn_release_o[g])
      );
   end

   assign any_press_o = |btn_press_o;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: randomized and directed stimulus against a run-length
// reference model (level flips after DB consecutive disagreeing samples).
// Auto-repeat expectations are included when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
module tb_key_debounce;

   localparam int NK = 4;
   localparam int DB = 8;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
   localparam int RD = 20;
   localparam int RP = 6;
   localparam int EXP_P0 = 6;
`else
   localparam int EXP_P0 = 1;
`endif

   logic          clk_50m = 1'b0;
   logic          rst_i;
   logic [NK-1:0] key_i;
   logic [NK-1:0] btn_level_o, btn_press_o, btn_release_o;
   logic          any_press_o;
   logic [NK-1:0] keyp;   // pressed view of the pins, 1 = pressed

   assign key_i = ~keyp;

   key_debounce #(
      .N_KEYS         (NK),
      .DB_CYCLES      (DB),
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
`endif
      .KEY_ACTIVE_LOW (1'b1)
   ) dut (
      .clk_50m       (clk_50m),
      .rst_i         (rst_i),
      .key_i         (key_i),
      .btn_level_o   (btn_level_o),
      .btn_press_o   (btn_press_o),
      .btn_release_o (btn_release_o),
      .any_press_o   (any_press_o)
   );

   always #10 clk_50m = ~clk_50m;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model state
   logic [NK-1:0] s1, s2, m_lvl, m_prs, m_rel;
   int m_run [NK];
   int m_held[NK];

   // monitors
   int   pcnt[NK], rcnt[NK], pcyc[NK], rcyc[NK];
   logic lvl_seen[NK];
   logic allp, allr;
   int   pq[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      s1 = '0; s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int c = 0; c < NK; c++) begin
         m_run[c]  = 0;
         m_held[c] = 0;
      end
   endtask

   // Pins reach the decision point through a 2-sample delay; the level flips
   // once DB consecutive samples disagree with it.
   task automatic model_step();
      logic [NK-1:0] p;
      int pr;
      p  = s2;
      s2 = s1;
      s1 = keyp;
      m_prs = '0;
      m_rel = '0;
      for (int c = 0; c < NK; c++) begin
         pr = m_run[c];
         if (p[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
               m_lvl[c]  = p[c];
               m_run[c]  = 0;
               m_held[c] = 0;
               if (p[c]) m_prs[c] = 1'b1;
               else      m_rel[c] = 1'b1;
            end
         end else begin
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            if (m_lvl[c] && pr == 0) begin
               m_held[c]++;
               if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0))
                  m_prs[c] = 1'b1;
            end
`endif
            m_run[c] = 0;
         end
      end
   endtask

   task automatic clear_mon();
      for (int c = 0; c < NK; c++) begin
         pcnt[c] = 0; rcnt[c] = 0; pcyc[c] = -1; rcyc[c] = -1; lvl_seen[c] = 1'b0;
      end
      allp = 1'b0; allr = 1'b0;
      pq.delete();
   endtask

   task automatic step();
      @(posedge clk_50m);
      if (rst_i) model_reset();
      else       model_step();
      #1;
      cyc++;
      chk("level",   32'(btn_level_o),   32'(m_lvl));
      chk("press",   32'(btn_press_o),   32'(m_prs));
      chk("release", 32'(btn_release_o), 32'(m_rel));
      chk("any",     32'(any_press_o),   32'(|m_prs));
      for (int c = 0; c < NK; c++) begin
         if (btn_press_o[c]) begin
            if (pcnt[c] == 0) pcyc[c] = cyc;
            pcnt[c]++;
         end
         if (btn_release_o[c]) begin
            rcyc[c] = cyc;
            rcnt[c]++;
         end
         if (btn_level_o[c]) lvl_seen[c] = 1'b1;
      end
      if (btn_press_o[0]) pq.push_back(cyc);
      if (btn_press_o == 4'hF) allp = 1'b1;
      if (btn_release_o == 4'hF) allr = 1'b1;
   endtask

   task automatic hold(input logic [NK-1:0] p, input int n);
      keyp = p;
      for (int i = 0; i < n; i++) step();
   endtask

   int t0;

   initial begin
      rst_i = 1'b1;
      keyp  = '0;
      model_reset();
      clear_mon();
      hold(4'h0, 3);
      rst_i = 1'b0;
      hold(4'h0, 5);

      // clean press on key 0, then release with a short glitch
      clear_mon();
      t0 = cyc;
      for (int k = 0; k < 80; k++) begin
         keyp[0] = (k < 50) || (k >= 52 && k < 55);
         step();
      end
      chk("press_latency",   32'(pcyc[0] - t0), 32'd10);
      chk("press_count",     32'(pcnt[0]),      32'(EXP_P0));
      chk("release_latency", 32'(rcyc[0] - t0), 32'd65);
      chk("release_count",   32'(rcnt[0]),      32'd1);
      chk("others_quiet",    32'(pcnt[1] + pcnt[2] + pcnt[3]), 32'd0);

      // bounce on key 1 never accepted
      clear_mon();
      for (int r = 0; r < 4; r++) begin
         hold(4'b0010, 5);
         hold(4'b0000, 3);
      end
      hold(4'b0000, 20);
      chk("bounce_level",   32'(lvl_seen[1]),       32'd0);
      chk("bounce_strobes", 32'(pcnt[1] + rcnt[1]), 32'd0);

      // all keys together
      clear_mon();
      hold(4'hF, 20);
      hold(4'h0, 20);
      chk("simul_press",   32'(allp), 32'd1);
      chk("simul_release", 32'(allr), 32'd1);

      // asynchronous reset while key 2 is held
      clear_mon();
      hold(4'b0100, 15);
      #3;
      rst_i = 1'b1;
      #1;
      chk("rst_level",   32'(btn_level_o),   32'd0);
      chk("rst_press",   32'(btn_press_o),   32'd0);
      chk("rst_release", 32'(btn_release_o), 32'd0);
      chk("rst_any",     32'(any_press_o),   32'd0);
      model_reset();
      hold(4'b0100, 2);
      rst_i = 1'b0;
      clear_mon();
      t0 = cyc;
      hold(4'b0100, 20);
      chk("rst_repress_latency", 32'(pcyc[2] - t0), 32'd10);
      chk("rst_no_release",      32'(rcnt[2]),      32'd0);
      hold(4'b0000, 20);

      // random bouncing on all channels
      for (int seg = 0; seg < 80; seg++) begin
         hold(keyp ^ 4'($urandom_range(0, 15)), $urandom_range(1, 14));
      end
      hold(4'h0, 20);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      // auto-repeat: strobes at +0,+20,+26,+32,+38,+44 from the level rise
      begin
         int exp_off[6];
         exp_off = '{0, 20, 26, 32, 38, 44};
         clear_mon();
         t0 = cyc;
         hold(4'b0001, 55);
         hold(4'b0000, 20);
         chk("rpt_count", 32'(pq.size()), 32'd6);
         for (int i = 0; i < 6 && i < pq.size(); i++)
            chk("rpt_offset", 32'(pq[i] - t0 - 10), 32'(exp_off[i]));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
